// File: rtl/nand_dq_arbiter.sv
// Round-robin owner arbitration for the shared NAND DQ bus: registered tristate
// enable, high-Z turnaround between owners, read sampling and sticky contention flag.
module nand_dq_arbiter #(
    parameter int W           = 4,
    parameter int TURN_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [1:0]   drv,
    input  logic [W-1:0] wdata0,
    input  logic [W-1:0] wdata1,
    output logic [1:0]   gnt,
    output logic         busy,
    output logic [W-1:0] dq_out,
    output logic         dq_oe,
    input  logic [W-1:0] dq_in,
    output logic [W-1:0] rdata,
    output logic         rvalid,
    input  logic         clr_err,
    output logic         err
);

    localparam int CW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam logic [CW-1:0] TURN_LOAD = (TURN_CYCLES > 0) ? CW'(TURN_CYCLES - 1) : {CW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          owner_r, owner_s;
    logic          last_owner_r, last_owner_s;
    logic [1:0]    gnt_r;
    logic          busy_r;
    logic [W-1:0]  dq_out_r;
    logic          dq_oe_r;
    logic [W-1:0]  rdata_r;
    logic          rvalid_r;
    logic          err_r;

    logic          in_grant_s;
    logic          own_req_s;
    logic          own_drv_s;
    logic [W-1:0]  own_wdata_s;
    logic          drive_s;
    logic          sample_s;

    assign in_grant_s  = (state_r == ST_GRANT);
    assign own_req_s   = req[owner_r];
    assign own_drv_s   = drv[owner_r];
    assign own_wdata_s = owner_r ? wdata1 : wdata0;
    assign drive_s     = in_grant_s && own_req_s && own_drv_s;
    assign sample_s    = in_grant_s && own_req_s && !own_drv_s && !dq_oe_r;

    // Next-state, turnaround counter and arbitration decision
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        owner_s      = owner_r;
        last_owner_s = last_owner_r;
        case (state_r)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    state_s = ST_GRANT;
                    if (req == 2'b11) begin
                        owner_s = ~last_owner_r;
                    end else begin
                        owner_s = req[1];
                    end
                    last_owner_s = owner_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // No preemption: only the owner's own req ends the grant
                if (!own_req_s) begin
                    if (TURN_CYCLES == 0) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_TURN;
                        cnt_s   = TURN_LOAD;
                    end
                end else begin
                    state_s = ST_GRANT;
                end
            end
            ST_TURN: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // State and registered bus-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CW{1'b0}};
            owner_r      <= 1'b0;
            last_owner_r <= 1'b1;
            gnt_r        <= 2'b00;
            busy_r       <= 1'b0;
            dq_out_r     <= {W{1'b0}};
            dq_oe_r      <= 1'b0;
            rdata_r      <= {W{1'b0}};
            rvalid_r     <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            owner_r      <= owner_s;
            last_owner_r <= last_owner_s;
            gnt_r        <= (state_s == ST_GRANT) ? (owner_s ? 2'b10 : 2'b01) : 2'b00;
            busy_r       <= (state_s != ST_IDLE);
            dq_oe_r      <= drive_s;
            if (drive_s) begin
                dq_out_r <= own_wdata_s;
            end
            rvalid_r     <= sample_s;
            if (sample_s) begin
                rdata_r <= dq_in;
            end
            // Case inequality so an undriven or unknown pad also counts as contention
            if (dq_oe_r && (dq_in !== dq_out_r)) begin
                err_r <= 1'b1;
            end else if (clr_err) begin
                err_r <= 1'b0;
            end
        end
    end

    assign gnt    = gnt_r;
    assign busy   = busy_r;
    assign dq_out = dq_out_r;
    assign dq_oe  = dq_oe_r;
    assign rdata  = rdata_r;
    assign rvalid = rvalid_r;
    assign err    = err_r;

endmodule
